core_column_readout: RTL and testbench

Token-chain readout controller for one core column of pixel regions. It sits directly downstream of the pixel-region logic. For each readout request it:
- broadcasts the trigger tag on `TrigIdReq`;
- drives `Read` strobes while the region token chain reports pending data;
- captures the wired-OR 16-bit `DataToCore` bus;
- frames the result as header, hit and trailer words in an output FIFO for the chip-level data merger.

---
 rtl/core_column_readout.sv | 134 +++++++++++++
 tb/tb_core_column_readout.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_column_readout.sv
// core_column_readout: token-chain readout of one pixel core column into a framed output FIFO.
// Optional feature: define CORE_READOUT_ZERO_SUPPRESS_EN to drop all-zero captured hits.
module core_column_readout #(
    parameter int FIFO_DEPTH = 16,
    parameter int SETTLE_CYC = 2,
    parameter int READ_LAT   = 1,
    parameter int MAX_HITS   = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic [4:0]  ReqTag,
    output logic        ReqReady,
    output logic [4:0]  TrigIdReq,
    input  logic        TokIn,
    output logic        Read,
    input  logic [15:0] DataToCore,
    output logic [17:0] OutData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        Busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SETTLE, READ, CAPT, TRAIL} state_t;

    state_t        state_q, state_d;
    logic [4:0]    tag_q, tag_d;
    logic [3:0]    tmr_q, tmr_d;
    logic [9:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [17:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   occ_q;
    logic          push, pop, room;
    logic [17:0]   wdata;

    assign room      = occ_q <= (AW+1)'(FIFO_DEPTH - 2);
    assign pop       = OutValid & OutReady;
    assign ReqReady  = (state_q == IDLE) & room & ~Reset;
    assign Read      = state_q == READ;
    assign Busy      = state_q != IDLE;
    assign TrigIdReq = tag_q;
    assign OutValid  = occ_q != '0;
    assign OutData   = OutValid ? mem_q[rp_q] : '0;

    // next-state, event bookkeeping and the word to push this cycle
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        wdata   = {2'b01, tag_q, 11'b0};
        case (state_q)
            IDLE: if (ReqValid && ReqReady) begin
                tag_d   = ReqTag;
                push    = 1'b1;
                wdata   = {2'b01, ReqTag, 11'b0};
                cnt_d   = '0;
                ovf_d   = 1'b0;
                tmr_d   = 4'(SETTLE_CYC - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (tmr_q != '0) tmr_d = tmr_q - 4'd1;
                else if (!TokIn) state_d = TRAIL;
                else if ({1'b0, cnt_q} == 11'(MAX_HITS)) begin
                    ovf_d   = 1'b1;
                    state_d = TRAIL;
                end
                else if (room) state_d = READ;
            end
            READ: begin
                tmr_d   = 4'(READ_LAT - 1);
                state_d = CAPT;
            end
            CAPT: begin
                if (tmr_q != '0) tmr_d = tmr_q - 4'd1;
                else begin
                    state_d = SETTLE;
                    tmr_d   = 4'(SETTLE_CYC - 1);
                    wdata   = {2'b00, DataToCore};
`ifdef CORE_READOUT_ZERO_SUPPRESS_EN
                    push    = DataToCore != 16'h0000;
`else
                    push    = 1'b1;
`endif
                    if (push && cnt_q != 10'h3FF) cnt_d = cnt_q + 10'd1;
                end
            end
            TRAIL: begin
                push    = 1'b1;
                wdata   = {2'b10, tag_q, ovf_q, cnt_q};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // controller state registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            tag_q   <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // output FIFO; the 2-free-word reservation guarantees push never hits a full FIFO
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= wdata;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
            occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_core_column_readout.sv
// tb_core_column_readout: directed checks of three readout instances (default, MAX_HITS=2, FIFO_DEPTH=4).
module tb_core_column_readout;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  tag = '0;
    logic [2:0]  rv = '0, rdy = 3'b111;
    logic [2:0]  rr, tok, rd, vld, busy;
    logic [4:0]  tid [3];
    logic [15:0] dq [3];
    logic [17:0] od [3];
    int          ntok [3];
    logic [15:0] tbl [16];
    logic [3:0]  nrd [3];
    logic [4:0]  ng [3];
    logic [17:0] got [3][32];
    int          rdc [3][16];
    int          cyc = 0;
    int          checks = 0, errors = 0;

    always #5 Clk = ~Clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : inst
            assign tok[g] = int'(nrd[g]) < ntok[g];
            core_column_readout #(
                .FIFO_DEPTH(g == 2 ? 4 : 16),
                .SETTLE_CYC(2),
                .READ_LAT(1),
                .MAX_HITS(g == 1 ? 2 : 64)
            ) dut (
                .Clk(Clk), .Reset(Reset), .ReqValid(rv[g]), .ReqTag(tag), .ReqReady(rr[g]),
                .TrigIdReq(tid[g]), .TokIn(tok[g]), .Read(rd[g]), .DataToCore(dq[g]),
                .OutData(od[g]), .OutValid(vld[g]), .OutReady(rdy[g]), .Busy(busy[g])
            );
        end
    endgenerate

    // region-chain model (one-cycle read latency) and output word collector
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (Reset) begin
                nrd[k] <= '0;
                ng[k]  <= '0;
                dq[k]  <= '0;
            end else begin
                if (rd[k]) begin
                    rdc[k][nrd[k]] <= cyc;
                    nrd[k] <= nrd[k] + 4'd1;
                end
                dq[k] <= rd[k] ? tbl[nrd[k]] : 16'h0;
                if (vld[k] && rdy[k]) begin
                    got[k][ng[k]] <= od[k];
                    ng[k] <= ng[k] + 5'd1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic do_reset;
        Reset = 1'b1; rv = '0; rdy = 3'b111;
        tick(2);
        Reset = 1'b0;
        tick(1);
    endtask

    task automatic accept(input int k, input logic [4:0] t, output int T);
        tag = t; rv[k] = 1'b1;
        checks++;
        if (rr[k] !== 1'b1) begin errors++; $display("FAIL accept%0d ReqReady=%b want 1", k, rr[k]); end
        tick(1);
        rv[k] = 1'b0;
        T = cyc - 1;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy[k] && n < 200) begin tick(1); n++; end
        checks++;
        if (busy[k] !== 1'b0) begin errors++; $display("FAIL idle_timeout%0d Busy=%b want 0", k, busy[k]); end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) ntok[k] = 0;
        Reset = 1'b1; rv = '0; rdy = 3'b111;
        tick(2);
        checks++; if (rr !== 3'b000) begin errors++; $display("FAIL rst_ready got %b want 000", rr); end
        checks++; if (vld !== 3'b000) begin errors++; $display("FAIL rst_valid got %b want 000", vld); end
        checks++; if (od[0] !== 18'h0) begin errors++; $display("FAIL rst_data got %h want 0", od[0]); end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL rst_busy got %b want 000", busy); end
        checks++; if (rd !== 3'b000) begin errors++; $display("FAIL rst_read got %b want 000", rd); end
        checks++; if (tid[0] !== 5'h0) begin errors++; $display("FAIL rst_tag got %h want 0", tid[0]); end
        Reset = 1'b0;
        tick(1);
        checks++; if (rr !== 3'b111) begin errors++; $display("FAIL rst_ready_after got %b want 111", rr); end
    endtask

    task automatic test_empty;
        int T;
        do_reset();
        ntok[0] = 0;
        accept(0, 5'h0A, T);
        checks++; if (vld[0] !== 1'b1 || od[0] !== 18'h1_5000) begin errors++; $display("FAIL empty_header got %b/%h want 1/15000", vld[0], od[0]); end
        checks++; if (tid[0] !== 5'h0A) begin errors++; $display("FAIL empty_tag got %h want 0a", tid[0]); end
        tick(2);
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL empty_trail_busy got %b want 1", busy[0]); end
        tick(1);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL empty_idle got %b want 0", busy[0]); end
        checks++; if (vld[0] !== 1'b1 || od[0] !== 18'h2_5000) begin errors++; $display("FAIL empty_trailer got %b/%h want 1/25000", vld[0], od[0]); end
        checks++; if (nrd[0] !== 4'd0) begin errors++; $display("FAIL empty_reads got %0d want 0", nrd[0]); end
    endtask

    task automatic test_three_hits;
        int T;
        logic [17:0] e [5];
        do_reset();
        tbl[0] = 16'h1234; tbl[1] = 16'h00F0; tbl[2] = 16'hFFFF;
        ntok[0] = 3;
        e[0] = 18'h1_1800; e[1] = 18'h0_1234; e[2] = 18'h0_00F0; e[3] = 18'h0_FFFF; e[4] = 18'h2_1803;
        accept(0, 5'h03, T);
        wait_idle(0);
        tick(2);
        checks++; if (ng[0] !== 5'd5) begin errors++; $display("FAIL hits_words got %0d want 5", ng[0]); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got[0][i] !== e[i]) begin errors++; $display("FAIL hits_word%0d got %h want %h", i, got[0][i], e[i]); end
        end
        checks++; if (rdc[0][0] != T + 3) begin errors++; $display("FAIL hits_first_read got %0d want %0d", rdc[0][0], T + 3); end
        checks++; if (rdc[0][1] - rdc[0][0] != 4) begin errors++; $display("FAIL hits_space1 got %0d want 4", rdc[0][1] - rdc[0][0]); end
        checks++; if (rdc[0][2] - rdc[0][1] != 4) begin errors++; $display("FAIL hits_space2 got %0d want 4", rdc[0][2] - rdc[0][1]); end
        ntok[0] = 0;
    endtask

    task automatic test_max_hits;
        int T;
        logic [17:0] e [4];
        do_reset();
        tbl[0] = 16'hA5A5; tbl[1] = 16'h5A5A;
        ntok[1] = 100;
        e[0] = 18'h1_F800; e[1] = 18'h0_A5A5; e[2] = 18'h0_5A5A; e[3] = 18'h2_FC02;
        accept(1, 5'h1F, T);
        wait_idle(1);
        tick(2);
        checks++; if (nrd[1] !== 4'd2) begin errors++; $display("FAIL max_reads got %0d want 2", nrd[1]); end
        checks++; if (ng[1] !== 5'd4) begin errors++; $display("FAIL max_words got %0d want 4", ng[1]); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[1][i] !== e[i]) begin errors++; $display("FAIL max_word%0d got %h want %h", i, got[1][i], e[i]); end
        end
        ntok[1] = 0;
    endtask

    task automatic test_fifo_stall;
        int T;
        logic [17:0] e [7];
        do_reset();
        rdy[2] = 1'b0;
        tbl[0] = 16'h0011; tbl[1] = 16'h0022; tbl[2] = 16'h0033; tbl[3] = 16'h0044; tbl[4] = 16'h0055;
        ntok[2] = 5;
        e[0] = 18'h1_2800; e[1] = 18'h0_0011; e[2] = 18'h0_0022; e[3] = 18'h0_0033;
        e[4] = 18'h0_0044; e[5] = 18'h0_0055; e[6] = 18'h2_2805;
        accept(2, 5'h05, T);
        tick(30);
        checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL stall_busy got %b want 1", busy[2]); end
        checks++; if (nrd[2] !== 4'd2) begin errors++; $display("FAIL stall_reads got %0d want 2", nrd[2]); end
        checks++; if (vld[2] !== 1'b1 || od[2] !== 18'h1_2800) begin errors++; $display("FAIL stall_head got %b/%h want 1/12800", vld[2], od[2]); end
        rdy[2] = 1'b1;
        wait_idle(2);
        tick(3);
        checks++; if (ng[2] !== 5'd7) begin errors++; $display("FAIL stall_words got %0d want 7", ng[2]); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (got[2][i] !== e[i]) begin errors++; $display("FAIL stall_word%0d got %h want %h", i, got[2][i], e[i]); end
        end
        ntok[2] = 0;
    endtask

    task automatic test_reset_mid;
        int T, n;
        do_reset();
        tbl[0] = 16'h7777; ntok[0] = 3;
        accept(0, 5'h11, T);
        n = 0;
        while (!rd[0] && n < 20) begin tick(1); n++; end
        checks++; if (rd[0] !== 1'b1) begin errors++; $display("FAIL mid_read_seen got %b want 1", rd[0]); end
        Reset = 1'b1;
        tick(1);
        checks++; if (rd[0] !== 1'b0) begin errors++; $display("FAIL mid_read got %b want 0", rd[0]); end
        checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", vld[0]); end
        checks++; if (busy[0] !== 1'b0 || tid[0] !== 5'h0) begin errors++; $display("FAIL mid_state busy/tag got %b/%h want 0/0", busy[0], tid[0]); end
        checks++; if (rr[0] !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset got %b want 0", rr[0]); end
        Reset = 1'b0;
        tick(1);
        checks++; if (rr[0] !== 1'b1) begin errors++; $display("FAIL mid_ready_after got %b want 1", rr[0]); end
        tick(6);
        checks++; if (vld[0] !== 1'b0 || ng[0] !== 5'd0) begin errors++; $display("FAIL mid_no_trailer valid/words got %b/%0d want 0/0", vld[0], ng[0]); end
        ntok[0] = 0;
    endtask

    task automatic test_zero_word;
        int T;
        do_reset();
        tbl[0] = 16'h0000; tbl[1] = 16'h00AB;
        ntok[0] = 2;
        accept(0, 5'h0C, T);
        wait_idle(0);
        tick(2);
`ifdef CORE_READOUT_ZERO_SUPPRESS_EN
        checks++; if (ng[0] !== 5'd3) begin errors++; $display("FAIL zero_words got %0d want 3", ng[0]); end
        checks++; if (got[0][1] !== 18'h0_00AB) begin errors++; $display("FAIL zero_hit got %h want 000ab", got[0][1]); end
        checks++; if (got[0][2] !== 18'h2_6001) begin errors++; $display("FAIL zero_trailer got %h want 26001", got[0][2]); end
`else
        checks++; if (ng[0] !== 5'd4) begin errors++; $display("FAIL zero_words got %0d want 4", ng[0]); end
        checks++; if (got[0][1] !== 18'h0_0000) begin errors++; $display("FAIL zero_hit0 got %h want 00000", got[0][1]); end
        checks++; if (got[0][2] !== 18'h0_00AB) begin errors++; $display("FAIL zero_hit1 got %h want 000ab", got[0][2]); end
        checks++; if (got[0][3] !== 18'h2_6002) begin errors++; $display("FAIL zero_trailer got %h want 26002", got[0][3]); end
`endif
        checks++; if (got[0][0] !== 18'h1_6000) begin errors++; $display("FAIL zero_header got %h want 16000", got[0][0]); end
        ntok[0] = 0;
    endtask

    initial begin
        test_reset();
        test_empty();
        test_three_hits();
        test_max_hits();
        test_fifo_stall();
        test_reset_mid();
        test_zero_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
